// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl
// Multi-cycle RV32I control unit. It walks the datapath through FETCH, DECODE,
// EXECUTE and MEM. It holds the fetched instruction in an instruction register.
// It drives every mux select, ALU operation and write enable.
// It talks to the instruction and data memories through ready handshakes.
// A wait counter puts the FSM into HALT with a sticky bus error when a memory
// stays silent for MEM_WAIT_MAX cycles. Setting MEM_WAIT_MAX to 0 disables it.
// Optional feature macro: RV32I_ILLEGAL_TRAP_EN. When it is defined, an
// unknown opcode halts the core and raises oIllegal. When it is not defined,
// an unknown opcode runs as a NOP and oIllegal is tied low.
module rv32i_multicycle_ctrl #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic        iClk,
   input  logic        iRst,
   output logic        oInst_Req,
   input  logic        iInst_Ready,
   input  logic [31:0] iInst_RdData,
   output logic [31:0] oInst_Code,
   input  logic        iBtaken,
   output logic [3:0]  oALU_Control,
   output logic        oALUSrcMuxSel1,
   output logic        oALUSrcMuxSel2,
   output logic [1:0]  oRegWrDataSel,
   output logic        oWrEn,
   output logic [1:0]  oPC_Sel,
   output logic        oPC_En,
   output logic        oData_Req,
   output logic        oData_We,
   input  logic        iData_Ready,
   output logic        oBus_Err,
   output logic        oIllegal
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   localparam logic [3:0] ALU_ADD = 4'b0000;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_IMM  = 2'd2;
   localparam logic [1:0] WB_PC4  = 2'd3;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_ALU    = 2'd2;

   // The counter only has to reach the limit. When the timeout is disabled,
   // it saturates so that it never wraps around.
   localparam int unsigned         CNT_W      = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CNT_W:0]      WAIT_LIMIT = (CNT_W + 1)'(MEM_WAIT_MAX);
   localparam bit                  TIMEOUT_EN = (MEM_WAIT_MAX != 0);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        inst_q, inst_d;
   logic [CNT_W-1:0]   wait_q, wait_d;
   logic               bus_err_q, bus_err_d;

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic               funct7_5;
   logic               rd_nz;
   logic               is_store;
   logic [CNT_W:0]     wait_inc;
   logic [CNT_W-1:0]   wait_sat;
   logic               wait_expired;

   logic               inst_req_c;
   logic [3:0]         alu_c;
   logic               sel1_c;
   logic               sel2_c;
   logic [1:0]         rwsel_c;
   logic               wr_c;
   logic [1:0]         pcsel_c;
   logic               pcen_c;
   logic               dreq_c;
   logic               dwe_c;

`ifdef RV32I_ILLEGAL_TRAP_EN
   logic               illegal_q, illegal_d;
`endif

   assign opcode   = inst_q[6:0];
   assign funct3   = inst_q[14:12];
   assign funct7_5 = inst_q[30];
   assign rd_nz    = (inst_q[11:7] != 5'd0);
   assign is_store = (opcode == OP_STORE);

   // Compute the next count for a cycle without ready, and check whether that
   // count hits the limit.
   always_comb begin
      wait_inc     = {1'b0, wait_q} + 1'b1;
      wait_sat     = wait_inc[CNT_W] ? wait_q : wait_inc[CNT_W-1:0];
      wait_expired = TIMEOUT_EN && (wait_inc == WAIT_LIMIT);
   end

   // Next-state and control decode. Every control defaults to zero, so HALT
   // and DECODE are quiet without listing anything.
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      wait_d     = wait_q;
      bus_err_d  = bus_err_q;
`ifdef RV32I_ILLEGAL_TRAP_EN
      illegal_d  = illegal_q;
`endif
      inst_req_c = 1'b0;
      alu_c      = ALU_ADD;
      sel1_c     = 1'b0;
      sel2_c     = 1'b0;
      rwsel_c    = WB_ALU;
      wr_c       = 1'b0;
      pcsel_c    = PC_PLUS4;
      pcen_c     = 1'b0;
      dreq_c     = 1'b0;
      dwe_c      = 1'b0;

      case (state_q)
         S_FETCH: begin
            inst_req_c = 1'b1;
            if (iInst_Ready) begin
               inst_d  = iInst_RdData;
               wait_d  = '0;
               state_d = S_DECODE;
            end else begin
               wait_d = wait_sat;
               if (wait_expired) begin
                  state_d   = S_HALT;
                  bus_err_d = 1'b1;
               end
            end
         end

         S_DECODE: begin
            state_d = S_EXECUTE;
         end

         S_EXECUTE: begin
            state_d = S_FETCH;
            pcen_c  = 1'b1;
            case (opcode)
               OP_R: begin
                  alu_c = {funct7_5, funct3};
                  wr_c  = rd_nz;
               end
               OP_I: begin
                  alu_c  = {funct7_5 & (funct3 == 3'b101), funct3};
                  sel2_c = 1'b1;
                  wr_c   = rd_nz;
               end
               OP_LUI: begin
                  rwsel_c = WB_IMM;
                  wr_c    = rd_nz;
               end
               OP_AUIPC: begin
                  sel1_c = 1'b1;
                  sel2_c = 1'b1;
                  wr_c   = rd_nz;
               end
               OP_JAL: begin
                  pcsel_c = PC_BRANCH;
                  rwsel_c = WB_PC4;
                  wr_c    = rd_nz;
               end
               OP_JALR: begin
                  sel2_c  = 1'b1;
                  pcsel_c = PC_ALU;
                  rwsel_c = WB_PC4;
                  wr_c    = rd_nz;
               end
               OP_BRANCH: begin
                  alu_c   = {1'b0, funct3};
                  pcsel_c = iBtaken ? PC_BRANCH : PC_PLUS4;
               end
               OP_LOAD, OP_STORE: begin
                  sel2_c  = 1'b1;
                  pcen_c  = 1'b0;
                  state_d = S_MEM;
               end
               default: begin
`ifdef RV32I_ILLEGAL_TRAP_EN
                  pcen_c    = 1'b0;
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
`else
                  pcen_c    = 1'b1;
`endif
               end
            endcase
         end

         S_MEM: begin
            sel2_c = 1'b1;
            dreq_c = 1'b1;
            dwe_c  = is_store;
            if (iData_Ready) begin
               wait_d  = '0;
               pcen_c  = 1'b1;
               state_d = S_FETCH;
               if (!is_store) begin
                  rwsel_c = WB_LOAD;
                  wr_c    = rd_nz;
               end
            end else begin
               wait_d = wait_sat;
               if (wait_expired) begin
                  state_d   = S_HALT;
                  bus_err_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   // State, instruction register, wait counter and sticky bus error.
   // Reset puts the FSM back in FETCH with a NOP latched.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q   <= S_FETCH;
         inst_q    <= NOP_INST;
         wait_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         inst_q    <= inst_d;
         wait_q    <= wait_d;
         bus_err_q <= bus_err_d;
      end
   end

`ifdef RV32I_ILLEGAL_TRAP_EN
   // Sticky illegal-opcode flag. Only reset clears it.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign oIllegal = ~iRst & illegal_q;
`else
   assign oIllegal = 1'b0;
`endif

   // While reset is high, every control is held low. This also covers a load
   // or store that is abandoned mid-access, so the PC cannot advance.
   assign oInst_Req      = ~iRst & inst_req_c;
   assign oInst_Code     = inst_q;
   assign oALU_Control   = iRst ? 4'd0 : alu_c;
   assign oALUSrcMuxSel1 = ~iRst & sel1_c;
   assign oALUSrcMuxSel2 = ~iRst & sel2_c;
   assign oRegWrDataSel  = iRst ? 2'd0 : rwsel_c;
   assign oWrEn          = ~iRst & wr_c;
   assign oPC_Sel        = iRst ? 2'd0 : pcsel_c;
   assign oPC_En         = ~iRst & pcen_c;
   assign oData_Req      = ~iRst & dreq_c;
   assign oData_We       = ~iRst & dwe_c;
   assign oBus_Err       = ~iRst & bus_err_q;

endmodule
